multdiv_ctrl: RTL and testbench
===============================

Name: multdiv_ctrl

Overview:
Sequencing controller between the pipeline's execute stage and the multicycle multdiv unit. Accepts one mult/div request at a time and drives a single-cycle ctrl_MULT/ctrl_DIV start pulse. Holds the operands stable for the whole operation and stalls the issuing stage while busy. Captures the result on data_resultRDY and presents it to writeback with a valid/ready handshake, plus timeout and flush handling.

Parameters:
TIMEOUT, 40, max cycles in RUN before forced abort with exception; must exceed worst-case div latency (33).
CNT_W, 6, timeout counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
clock  in  1  system clock, rising edge
resetn  in  1  asynchronous active-low reset
req_valid  in  1  execute stage presents a mult/div
req_op  in  1  0 = mult, 1 = div
req_a  in  32  operand A
req_b  in  32  operand B
req_rd  in  5  destination register
flush  in  1  kill in-flight op (branch mispredict/exception)
stall  out  1  issuing stage must hold its request
busy  out  1  state != IDLE
md_operandA  out  32  to multdiv data_operandA
md_operandB  out  32  to multdiv data_operandB
md_ctrl_MULT  out  1  start pulse, mult
md_ctrl_DIV  out  1  start pulse, div
md_result  in  32  multdiv data_result
md_exception  in  1  multdiv data_exception
md_resultRDY  in  1  multdiv data_resultRDY
wb_valid  out  1  result available
wb_ready  in  1  writeback accepts this cycle
wb_rd  out  5  destination register
wb_data  out  32  result
wb_exception  out  1  overflow/div-by-zero/timeout

Behaviour:
- Reset (resetn low, async): state = IDLE; operand, rd, op, result, exception registers = 0; timeout count = 0. All outputs 0.
- States: IDLE, START, RUN, DONE.
- Accept = req_valid & ~flush & (state == IDLE | (state == DONE & wb_ready)). On accept, latch req_a/req_b/req_op/req_rd and go to START.
- stall = req_valid & ~accept. While flush is high, stall = req_valid.
- START: exactly one cycle. md_ctrl_MULT = ~op, md_ctrl_DIV = op; both 0 in every other state. Next state is RUN and the timeout count clears to 0.
- RUN: the timeout count increments each cycle.
  - md_resultRDY = 1: capture md_result and md_exception, then go to DONE.
  - Count reaches TIMEOUT - 1 without RDY: capture result 0 with exception 1, then go to DONE.
  - RDY on the same cycle as the timeout limit: RDY wins.
- md_resultRDY is sampled only in RUN; it is ignored in IDLE, START and DONE.
- md_operandA/B are driven from the latched registers in all states. They change only on accept and never mid-operation.
- DONE: wb_valid = 1; wb_rd, wb_data and wb_exception come from the captured registers.
  - wb_ready & accept: next state START (back-to-back, no idle bubble).
  - wb_ready & ~accept: next state IDLE.
  - ~wb_ready: hold all wb_* outputs stable.
- wb_valid = 0 outside DONE, and wb_data = 0 then.
- Latency: accept at cycle 0, start pulse at cycle 1, RDY at cycle N, wb_valid at N+1.
- flush in START, RUN or DONE: next state IDLE and wb_valid drops the next cycle. Any later RDY is ignored. The multdiv unit needs no abort because the next start pulse restarts its counter.
- flush in IDLE: no effect except blocking accept.
- flush takes priority over wb_ready in DONE: the result is dropped even if wb_ready is high.
- Reset asserted mid-operation: immediate return to IDLE with outputs 0. No pulse is issued after reset release until a new accept.

Test Plan:
- Mult: req a=7, b=6, op=0, rd=5, wb_ready=1 -> md_ctrl_MULT high exactly 1 cycle at cycle 1; md_operandA/B stay 7/6 through RUN; stall high on any req_valid while busy; wb_valid 1 cycle with wb_rd=5, wb_data=42, wb_exception=0.
- Div by zero: a=100, b=0, op=1 -> md_ctrl_DIV single pulse; wb_exception=1, wb_data equal to md_result.
- Backpressure and back-to-back: first result with wb_ready=0 for 3 cycles -> wb_* held stable. Then wb_ready=1 with second req (a=20, b=4, op=1) -> START next cycle, no IDLE cycle, second wb_data=5.
- Flush mid-RUN at cycle 10 -> IDLE next cycle; the later md_resultRDY produces no wb_valid. A subsequent mult a=3, b=3 returns 9.
- Timeout: multdiv model never raises RDY -> DONE after TIMEOUT=40 RUN cycles with wb_data=0, wb_exception=1. RDY injected on the limit cycle -> real result, exception 0.
- resetn pulsed low mid-RUN -> all outputs 0 asynchronously; no ctrl pulse after release; a new request completes normally.

Source files
------------

// File: rtl/multdiv_ctrl.sv
// Sequencer between execute and the multicycle multdiv unit: issues one start
// pulse per request, holds operands, and hands the result to writeback.
module multdiv_ctrl #(
    parameter int TIMEOUT = 40,
    parameter int CNT_W   = 6
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        req_valid,
    input  logic        req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [4:0]  req_rd,
    input  logic        flush,
    output logic        stall,
    output logic        busy,
    output logic [31:0] md_operandA,
    output logic [31:0] md_operandB,
    output logic        md_ctrl_MULT,
    output logic        md_ctrl_DIV,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    input  logic        md_resultRDY,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        wb_exception
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               accept;
    logic               cnt_limit;
    logic               op_q;
    logic [31:0]        a_q;
    logic [31:0]        b_q;
    logic [4:0]         rd_q;
    logic [31:0]        res_q;
    logic               exc_q;
    logic [CNT_W-1:0]   cnt_q;

    // A finishing result in DONE can be retired and replaced in the same cycle.
    assign accept    = req_valid & ~flush &
                       ((state == IDLE) | ((state == DONE) & wb_ready));
    assign cnt_limit = (cnt_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = START;
                end
            end
            START: begin
                state_nxt = flush ? IDLE : RUN;
            end
            RUN: begin
                if (flush) begin
                    state_nxt = IDLE;
                end else if (md_resultRDY || cnt_limit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (flush) begin
                    state_nxt = IDLE;
                end else if (wb_ready) begin
                    state_nxt = accept ? START : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        stall        = 1'b0;
        busy         = 1'b0;
        md_ctrl_MULT = 1'b0;
        md_ctrl_DIV  = 1'b0;
        wb_valid     = 1'b0;
        wb_rd        = 5'd0;
        wb_data      = 32'd0;
        wb_exception = 1'b0;
        if (resetn) begin
            stall = req_valid & ~accept;
            busy  = (state != IDLE);
            if (state == START) begin
                md_ctrl_MULT = ~op_q;
                md_ctrl_DIV  = op_q;
            end
            if (state == DONE) begin
                wb_valid     = 1'b1;
                wb_rd        = rd_q;
                wb_data      = res_q;
                wb_exception = exc_q;
            end
        end
    end

    // Operands only move on accept, so the unit sees them stable for the whole op.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            op_q <= 1'b0;
            a_q  <= 32'd0;
            b_q  <= 32'd0;
            rd_q <= 5'd0;
        end else if (accept) begin
            op_q <= req_op;
            a_q  <= req_a;
            b_q  <= req_b;
            rd_q <= req_rd;
        end
    end

    assign md_operandA = a_q;
    assign md_operandB = b_q;

    // RDY beats the timeout when both land on the same RUN cycle.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
            res_q <= 32'd0;
            exc_q <= 1'b0;
        end else begin
            if (state == START) begin
                cnt_q <= '0;
            end else if (state == RUN) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if ((state == RUN) && !flush) begin
                if (md_resultRDY) begin
                    res_q <= md_result;
                    exc_q <= md_exception;
                end else if (cnt_limit) begin
                    res_q <= 32'd0;
                    exc_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Self-checking bench for multdiv_ctrl with a behavioural multdiv unit model.
module tb_multdiv_ctrl;

    localparam int TIMEOUT = 40;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_op = 1'b0;
    logic [31:0] req_a = 32'd0;
    logic [31:0] req_b = 32'd0;
    logic [4:0]  req_rd = 5'd0;
    logic        flush = 1'b0;
    logic        stall, busy, md_ctrl_MULT, md_ctrl_DIV;
    logic [31:0] md_operandA, md_operandB, md_result;
    logic        md_exception, md_resultRDY;
    logic        wb_valid, wb_exception;
    logic        wb_ready = 1'b1;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int n_tests = 0;
    int n_fail  = 0;

    // multdiv unit model: latency m_lat cycles after the start pulse
    int          m_lat = 1;
    bit          m_never = 1'b0;
    logic        m_act;
    int          m_left;
    logic [31:0] m_res;
    logic        m_exc;

    multdiv_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(6)) dut (
        .clock(clock), .resetn(resetn),
        .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .req_rd(req_rd), .flush(flush), .stall(stall), .busy(busy),
        .md_operandA(md_operandA), .md_operandB(md_operandB),
        .md_ctrl_MULT(md_ctrl_MULT), .md_ctrl_DIV(md_ctrl_DIV),
        .md_result(md_result), .md_exception(md_exception),
        .md_resultRDY(md_resultRDY), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_rd(wb_rd), .wb_data(wb_data), .wb_exception(wb_exception)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] ref_res(input logic [31:0] a, b, input logic op);
        if (!op) return a * b;
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
    endfunction

    function automatic logic ref_exc(input logic [31:0] b, input logic op);
        return op && (b == 32'd0);
    endfunction

    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            m_act  <= 1'b0;
            m_left <= 0;
            m_res  <= 32'd0;
            m_exc  <= 1'b0;
        end else if (md_ctrl_MULT || md_ctrl_DIV) begin
            m_act  <= 1'b1;
            m_left <= m_lat;
            m_res  <= ref_res(md_operandA, md_operandB, md_ctrl_DIV);
            m_exc  <= ref_exc(md_operandB, md_ctrl_DIV);
        end else if (m_act) begin
            if (m_left <= 1) m_act <= 1'b0;
            else m_left <= m_left - 1;
        end
    end

    assign md_resultRDY = m_act && (m_left == 1) && !m_never;
    assign md_result    = m_res;
    assign md_exception = m_exc;

    // Issue one request from IDLE and follow it to writeback with wb_ready=1.
    // RDY lands at cycle lat+1; the timeout fires on cycle TIMEOUT+1.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic op,
                          input logic [4:0] rd, input int lat, input bit never, input bit poke);
        int          rdy_cyc, done_cyc;
        logic [31:0] ed;
        logic        ee;
        logic [4:0]  ctl_e, ctl_o;
        rdy_cyc = never ? 100000 : lat + 1;
        if (rdy_cyc <= TIMEOUT + 1) begin
            done_cyc = rdy_cyc + 1;
            ed = ref_res(a, b, op);
            ee = ref_exc(b, op);
        end else begin
            done_cyc = TIMEOUT + 2;
            ed = 32'd0;
            ee = 1'b1;
        end
        m_lat = lat;
        m_never = never;
        @(negedge clock);
        req_valid = 1'b1; req_a = a; req_b = b; req_op = op; req_rd = rd;
        wb_ready = 1'b1; flush = 1'b0;
        #1;
        n_tests++;
        if (stall !== 1'b0) begin
            n_fail++; $display("FAIL accept_stall: got %b want 0", stall);
        end
        for (int c = 1; c <= done_cyc + 1; c++) begin
            @(negedge clock);
            if (poke && c < done_cyc) begin
                req_valid = 1'b1; req_a = $urandom; req_b = $urandom;
                req_op = 1'($urandom); req_rd = 5'($urandom);
            end else begin
                req_valid = 1'b0;
            end
            #1;
            ctl_e = {c <= done_cyc, c == 1 && !op, c == 1 && op, c == done_cyc, poke && c < done_cyc};
            ctl_o = {busy, md_ctrl_MULT, md_ctrl_DIV, wb_valid, stall};
            n_tests++;
            if (ctl_o !== ctl_e) begin
                n_fail++; $display("FAIL ctl{busy,mult,div,wbv,stall} cyc %0d: got %b want %b", c, ctl_o, ctl_e);
            end
            if (c < done_cyc) begin
                n_tests++;
                if ({md_operandA, md_operandB} !== {a, b}) begin
                    n_fail++; $display("FAIL operands cyc %0d: got %h/%h want %h/%h", c, md_operandA, md_operandB, a, b);
                end
            end
            n_tests++;
            if (c == done_cyc) begin
                if ({wb_rd, wb_data, wb_exception} !== {rd, ed, ee}) begin
                    n_fail++; $display("FAIL wb_result: got rd=%0d data=%h exc=%b want rd=%0d data=%h exc=%b",
                                       wb_rd, wb_data, wb_exception, rd, ed, ee);
                end
            end else if (wb_data !== 32'd0) begin
                n_fail++; $display("FAIL wb_data_idle cyc %0d: got %h want 0", c, wb_data);
            end
        end
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        n_tests++;
        if ({stall, busy, md_ctrl_MULT, md_ctrl_DIV, wb_valid, wb_exception, wb_rd, wb_data, md_operandA, md_operandB} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: busy=%b wbv=%b opA=%h opB=%h wb_data=%h want all 0",
                               busy, wb_valid, md_operandA, md_operandB, wb_data);
        end
        @(negedge clock);
        resetn = 1'b1;
        repeat (2) @(negedge clock);
        #1;
        n_tests++;
        if ({busy, md_ctrl_MULT, md_ctrl_DIV, wb_valid} !== 4'b0) begin
            n_fail++; $display("FAIL post_reset_idle: got %b want 0000", {busy, md_ctrl_MULT, md_ctrl_DIV, wb_valid});
        end
    endtask

    task automatic test_mult();
        run_op(32'd7, 32'd6, 1'b0, 5'd5, 4, 1'b0, 1'b1);
    endtask

    task automatic test_div_zero();
        run_op(32'd100, 32'd0, 1'b1, 5'd7, 5, 1'b0, 1'b0);
        run_op(32'd100, 32'd7, 1'b1, 5'd8, 3, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        m_lat = 2; m_never = 1'b0;
        @(negedge clock);
        wb_ready = 1'b0;
        req_valid = 1'b1; req_a = 32'd9; req_b = 32'd8; req_op = 1'b0; req_rd = 5'd12;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clock);
            req_valid = 1'b0;
            #1;
            n_tests++;
            if (c >= 4) begin
                if ({wb_valid, wb_rd, wb_data, wb_exception} !== {1'b1, 5'd12, 32'd72, 1'b0}) begin
                    n_fail++; $display("FAIL backpressure_hold cyc %0d: got v=%b rd=%0d data=%0d exc=%b want 1/12/72/0",
                                       c, wb_valid, wb_rd, wb_data, wb_exception);
                end
            end else if (wb_valid !== 1'b0) begin
                n_fail++; $display("FAIL early_wb_valid cyc %0d: got %b want 0", c, wb_valid);
            end
        end
        @(negedge clock);
        wb_ready = 1'b1;
        req_valid = 1'b1; req_a = 32'd20; req_b = 32'd4; req_op = 1'b1; req_rd = 5'd3;
        #1;
        n_tests++;
        if ({wb_valid, wb_data, stall} !== {1'b1, 32'd72, 1'b0}) begin
            n_fail++; $display("FAIL b2b_handoff: got v=%b data=%0d stall=%b want 1/72/0", wb_valid, wb_data, stall);
        end
        @(negedge clock);
        req_valid = 1'b0;
        #1;
        n_tests++;
        if ({busy, md_ctrl_DIV, md_ctrl_MULT, wb_valid, wb_data, md_operandA} !== {4'b1100, 32'd0, 32'd20}) begin
            n_fail++; $display("FAIL b2b_start: got busy=%b div=%b mult=%b wbv=%b data=%h opA=%0d want 1/1/0/0/0/20",
                               busy, md_ctrl_DIV, md_ctrl_MULT, wb_valid, wb_data, md_operandA);
        end
        for (int c = 9; c <= 12; c++) begin
            @(negedge clock);
            #1;
            n_tests++;
            if ({busy, wb_valid} !== {c <= 11, c == 11}) begin
                n_fail++; $display("FAIL b2b_second_ctl cyc %0d: got busy=%b wbv=%b", c, busy, wb_valid);
            end
            if (c == 11) begin
                n_tests++;
                if ({wb_rd, wb_data, wb_exception} !== {5'd3, 32'd5, 1'b0}) begin
                    n_fail++; $display("FAIL b2b_second_result: got rd=%0d data=%0d exc=%b want 3/5/0", wb_rd, wb_data, wb_exception);
                end
            end
        end
    endtask

    task automatic test_flush();
        m_lat = 20; m_never = 1'b0;
        @(negedge clock);
        req_valid = 1'b1; req_a = 32'd11; req_b = 32'd2; req_op = 1'b0; req_rd = 5'd4;
        repeat (10) begin
            @(negedge clock);
            req_valid = 1'b0;
        end
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        for (int c = 11; c <= 28; c++) begin
            #1;
            n_tests++;
            if ({busy, wb_valid} !== 2'b00) begin
                n_fail++; $display("FAIL flush_run cyc %0d: got busy=%b wbv=%b want 0/0", c, busy, wb_valid);
            end
            @(negedge clock);
        end
        run_op(32'd3, 32'd3, 1'b0, 5'd9, 3, 1'b0, 1'b0);
        // flush in DONE beats wb_ready and a waiting request
        m_lat = 2;
        @(negedge clock);
        req_valid = 1'b1; req_a = 32'd2; req_b = 32'd2; req_op = 1'b0; req_rd = 5'd1;
        repeat (4) begin
            @(negedge clock);
            req_valid = 1'b0;
        end
        flush = 1'b1; req_valid = 1'b1;
        #1;
        n_tests++;
        if ({wb_valid, stall} !== 2'b11) begin
            n_fail++; $display("FAIL flush_done_same: got wbv=%b stall=%b want 1/1", wb_valid, stall);
        end
        @(negedge clock);
        flush = 1'b1;
        #1;
        n_tests++;
        if ({busy, wb_valid, stall} !== 3'b001) begin
            n_fail++; $display("FAIL flush_done_next: got busy=%b wbv=%b stall=%b want 0/0/1", busy, wb_valid, stall);
        end
        @(negedge clock);
        flush = 1'b0; req_valid = 1'b0;
        #1;
        n_tests++;
        if ({busy, md_ctrl_MULT, md_ctrl_DIV} !== 3'b000) begin
            n_fail++; $display("FAIL flush_idle_blocks: got %b want 000", {busy, md_ctrl_MULT, md_ctrl_DIV});
        end
    endtask

    task automatic test_timeout();
        run_op(32'd5, 32'd5, 1'b0, 5'd9, 1, 1'b1, 1'b0);
        run_op(32'd6, 32'd7, 1'b0, 5'd10, TIMEOUT, 1'b0, 1'b0);
        run_op(32'd6, 32'd7, 1'b1, 5'd11, TIMEOUT + 1, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        m_lat = 20; m_never = 1'b0;
        @(negedge clock);
        req_valid = 1'b1; req_a = 32'd13; req_b = 32'd3; req_op = 1'b1; req_rd = 5'd6;
        repeat (8) begin
            @(negedge clock);
            req_valid = 1'b0;
        end
        #2 resetn = 1'b0;
        #1;
        n_tests++;
        if ({stall, busy, md_ctrl_MULT, md_ctrl_DIV, wb_valid, wb_exception, wb_rd, wb_data, md_operandA, md_operandB} !== '0) begin
            n_fail++; $display("FAIL async_reset: busy=%b opA=%h opB=%h wbv=%b want all 0", busy, md_operandA, md_operandB, wb_valid);
        end
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        for (int c = 0; c < 25; c++) begin
            #1;
            n_tests++;
            if ({busy, md_ctrl_MULT, md_ctrl_DIV, wb_valid} !== 4'b0) begin
                n_fail++; $display("FAIL post_reset_quiet cyc %0d: got %b want 0000", c, {busy, md_ctrl_MULT, md_ctrl_DIV, wb_valid});
            end
            @(negedge clock);
        end
        run_op(32'd13, 32'd3, 1'b1, 5'd6, 6, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        logic        op;
        for (int i = 0; i < 10; i++) begin
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom_range(1, 100000);
            op = 1'($urandom);
            run_op(a, b, op, 5'($urandom), $urandom_range(1, TIMEOUT + 4), 1'b0, 1'($urandom));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_mult();
        test_div_zero();
        test_back_to_back();
        test_flush();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
